// File: rtl/renkon_linebuf_ctrl_if.sv
// Bundle between the layer scheduler, the feature memory and the line buffer.
// The controller sits on the slave modport; the surrounding environment drives the master side.
interface renkon_linebuf_ctrl_if #(
    parameter int LWIDTH     = 8,
    parameter int FADDRWIDTH = 16
);
    logic                  req;
    logic                  ack;
    logic [LWIDTH-1:0]     img_size;
    logic [LWIDTH-1:0]     fil_size;
    logic [LWIDTH-1:0]     pad_size;
    logic [LWIDTH-1:0]     n_in;
    logic [FADDRWIDTH-1:0] base_addr;
    logic [FADDRWIDTH-1:0] mem_addr;
    logic                  buf_req;
    logic                  buf_ack;
    logic                  buf_ready;
    logic                  buf_valid;
    logic                  win_first;
    logic                  win_last;
    logic [LWIDTH-1:0]     ch_count;
    logic                  done;

    modport master (
        output req, img_size, fil_size, pad_size, n_in, base_addr,
               buf_ack, buf_ready, buf_valid,
        input  ack, mem_addr, buf_req, win_first, win_last, ch_count, done
    );

    modport slave (
        input  req, img_size, fil_size, pad_size, n_in, base_addr,
               buf_ack, buf_ready, buf_valid,
        output ack, mem_addr, buf_req, win_first, win_last, ch_count, done
    );
endinterface

// File: rtl/renkon_linebuf_ctrl.sv
// Walks one line buffer across every input channel of a conv layer, generating
// feature read addresses and first/last-channel tags for each emitted window.
//
// state  | meaning
// S_IDLE | waiting for a layer request, config latched on accept
// S_REQ  | one-cycle buf_req to the line buffer for the current channel
// S_RUN  | buffer streaming pixels in and windows out
// S_NEXT | channel finished: step to next channel or end the layer
module renkon_linebuf_ctrl #(
    parameter int MAXIMG     = 32,
    parameter int MAXCH      = 64,
    parameter int FADDRWIDTH = 16,
    parameter int LWIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    renkon_linebuf_ctrl_if.slave  bus
);
    localparam int LW2 = 2 * LWIDTH;

    if (MAXIMG >= (1 << LWIDTH)) begin : g_img_range
        $error("MAXIMG does not fit in LWIDTH");
    end
    if (MAXCH > (1 << LWIDTH)) begin : g_ch_range
        $error("MAXCH does not fit in LWIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RUN,
        S_NEXT
    } state_t;

    state_t                state, state_nxt;
    logic [LWIDTH-1:0]     img_r, img_nxt;
    logic [LWIDTH-1:0]     fil_r, fil_nxt;
    logic [LWIDTH-1:0]     pad_r, pad_nxt;
    logic [LWIDTH-1:0]     nin_r, nin_nxt;
    logic [LWIDTH-1:0]     ch_r, ch_nxt;
    logic [FADDRWIDTH-1:0] addr_r, addr_nxt;
    logic [LW2-1:0]        in_cnt, in_cnt_nxt;
    logic [LW2-1:0]        out_cnt, out_cnt_nxt;
    logic [LW2-1:0]        img_w, osz_w, img_sq, osz_sq;
    logic                  pix_take;
    logic                  last_ch;
    logic                  ack, buf_req, done;

    assign img_w   = LW2'(img_r);
    assign osz_w   = img_w + (LW2'(pad_r) << 1) - LW2'(fil_r) + LW2'(1);
    assign img_sq  = img_w * img_w;
    assign osz_sq  = osz_w * osz_w;
    assign last_ch = (ch_r == nin_r - LWIDTH'(1));

    // Pixels are accepted in S_REQ too, so unpadded layers lose no cycle.
    assign pix_take = bus.buf_ready && (in_cnt < img_sq) &&
                      ((state == S_REQ) || (state == S_RUN));

    always_comb begin
        state_nxt   = state;
        img_nxt     = img_r;
        fil_nxt     = fil_r;
        pad_nxt     = pad_r;
        nin_nxt     = nin_r;
        ch_nxt      = ch_r;
        addr_nxt    = addr_r;
        in_cnt_nxt  = in_cnt;
        out_cnt_nxt = out_cnt;
        ack         = 1'b0;
        buf_req     = 1'b0;
        done        = 1'b0;

        if (pix_take) begin
            in_cnt_nxt = in_cnt + LW2'(1);
            addr_nxt   = addr_r + FADDRWIDTH'(1);
        end

        case (state)
            S_IDLE: begin
                ack = 1'b1;
                if (bus.req) begin
                    img_nxt     = bus.img_size;
                    fil_nxt     = bus.fil_size;
                    pad_nxt     = bus.pad_size;
                    nin_nxt     = bus.n_in;
                    addr_nxt    = bus.base_addr;
                    ch_nxt      = '0;
                    in_cnt_nxt  = '0;
                    out_cnt_nxt = '0;
                    state_nxt   = S_REQ;
                end
            end
            S_REQ: begin
                buf_req   = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.buf_valid) begin
                    out_cnt_nxt = out_cnt + LW2'(1);
                end
                // Window counted first so the last valid and the ack return can coincide.
                if ((out_cnt_nxt == osz_sq) && bus.buf_ack) begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last_ch) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    ch_nxt      = ch_r + LWIDTH'(1);
                    in_cnt_nxt  = '0;
                    out_cnt_nxt = '0;
                    state_nxt   = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            img_r   <= '0;
            fil_r   <= '0;
            pad_r   <= '0;
            nin_r   <= '0;
            ch_r    <= '0;
            addr_r  <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            state   <= state_nxt;
            img_r   <= img_nxt;
            fil_r   <= fil_nxt;
            pad_r   <= pad_nxt;
            nin_r   <= nin_nxt;
            ch_r    <= ch_nxt;
            addr_r  <= addr_nxt;
            in_cnt  <= in_cnt_nxt;
            out_cnt <= out_cnt_nxt;
        end
    end

    assign bus.ack       = ack;
    assign bus.buf_req   = buf_req;
    assign bus.done      = done;
    assign bus.mem_addr  = addr_r;
    assign bus.ch_count  = ch_r;
    assign bus.win_first = (state == S_RUN) && bus.buf_valid && (ch_r == '0);
    assign bus.win_last  = (state == S_RUN) && bus.buf_valid && last_ch;
endmodule

// File: tb/tb_renkon_linebuf_ctrl.sv
// Directed bench for renkon_linebuf_ctrl with a scripted line-buffer stand-in.
module tb_renkon_linebuf_ctrl;
    localparam int LW = 8;
    localparam int FW = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   breq_cnt = 0;
    int   d0, b0;

    renkon_linebuf_ctrl_if #(.LWIDTH(LW), .FADDRWIDTH(FW)) bus ();

    renkon_linebuf_ctrl #(
        .MAXIMG(32), .MAXCH(64), .FADDRWIDTH(FW), .LWIDTH(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.done)    done_cnt <= done_cnt + 1;
        if (bus.buf_req) breq_cnt <= breq_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic buf_idle();
        bus.buf_ready = 1'b0;
        bus.buf_valid = 1'b0;
        bus.buf_ack   = 1'b1;
        bus.req       = 1'b0;
    endtask

    task automatic start_layer(input int img, input int fil, input int pad,
                               input int nin, input int base);
        @(negedge clk);
        check("ack_before_req", 32'(bus.ack), 1);
        bus.img_size  = LW'(img);
        bus.fil_size  = LW'(fil);
        bus.pad_size  = LW'(pad);
        bus.n_in      = LW'(nin);
        bus.base_addr = FW'(base);
        bus.req       = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    // One channel: feed pix pixels, then emit wins windows with buf_ack rising on the last.
    task automatic run_ch(input int pix, input int wins, input bit rdy_in_req,
                          input bit extra_rdy, input bit poke, input int a0,
                          input bit ef, input bit el, input int ch, input bit last);
        int n = 0;
        int k = 0;
        while (!bus.buf_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("buf_req_seen", 32'(bus.buf_req), 1);
        check("ch_count", 32'(bus.ch_count), ch);
        check("ack_busy", 32'(bus.ack), 0);
        bus.buf_ack = 1'b0;
        if (rdy_in_req) begin
            check("addr_req_cycle", 32'(bus.mem_addr), a0);
            bus.buf_ready = 1'b1;
            k = 1;
        end
        while (k < pix) begin
            @(negedge clk);
            check("addr_pix", 32'(bus.mem_addr), a0 + k);
            bus.buf_ready = 1'b1;
            if (poke && k == 2) begin
                bus.req      = 1'b1;
                bus.img_size = LW'(8);
            end else begin
                bus.req = 1'b0;
            end
            k++;
        end
        @(negedge clk);
        bus.req       = 1'b0;
        bus.buf_ready = extra_rdy;
        check("addr_end", 32'(bus.mem_addr), a0 + pix);
        for (int w = 0; w < wins; w++) begin
            bus.buf_valid = 1'b1;
            bus.buf_ack   = (w == wins - 1);
            #1;
            check("win_first", 32'(bus.win_first), 32'(ef));
            check("win_last", 32'(bus.win_last), 32'(el));
            @(negedge clk);
        end
        bus.buf_valid = 1'b0;
        bus.buf_ready = 1'b0;
        check("addr_sat", 32'(bus.mem_addr), a0 + pix);
        check("ack_in_next", 32'(bus.ack), 0);
        check("done_pulse", 32'(bus.done), 32'(last));
        if (last) begin
            @(negedge clk);
            check("ack_after_done", 32'(bus.ack), 1);
            check("done_cleared", 32'(bus.done), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        buf_idle();
        bus.img_size  = '0;
        bus.fil_size  = '0;
        bus.pad_size  = '0;
        bus.n_in      = '0;
        bus.base_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Stray ready/valid while idle must not move anything.
        bus.buf_valid = 1'b1;
        bus.buf_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_ack", 32'(bus.ack), 1);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_ch_count", 32'(bus.ch_count), 0);
        check("rst_buf_req", 32'(bus.buf_req), 0);
        check("rst_done", 32'(bus.done), 0);
        check("idle_win_first", 32'(bus.win_first), 0);
        check("idle_win_last", 32'(bus.win_last), 0);
        buf_idle();

        // 1) img4 fil3 pad1, one channel, extra readies must saturate
        d0 = done_cnt;
        start_layer(4, 3, 1, 1, 'h100);
        run_ch(16, 16, 0, 1, 0, 'h100, 1, 1, 0, 1);
        check("t1_done_count", done_cnt - d0, 1);

        // 2) pad 0, ready asserted in the request cycle
        d0 = done_cnt;
        start_layer(4, 3, 0, 1, 'h80);
        run_ch(16, 4, 1, 0, 0, 'h80, 1, 1, 0, 1);
        check("t2_done_count", done_cnt - d0, 1);

        // 3) three channels, contiguous addresses
        d0 = done_cnt;
        b0 = breq_cnt;
        start_layer(4, 3, 1, 3, 0);
        run_ch(16, 16, 0, 0, 0, 0,  1, 0, 0, 0);
        run_ch(16, 16, 0, 0, 0, 16, 0, 0, 1, 0);
        run_ch(16, 16, 0, 0, 0, 32, 0, 1, 2, 1);
        check("t3_buf_req_count", breq_cnt - b0, 3);
        check("t3_done_count", done_cnt - d0, 1);

        // 4) img8 fil5 pad2, two channels of 64 windows
        d0 = done_cnt;
        start_layer(8, 5, 2, 2, 'h300);
        run_ch(64, 64, 0, 0, 0, 'h300, 1, 0, 0, 0);
        run_ch(64, 64, 0, 0, 0, 'h340, 0, 1, 1, 1);
        check("t4_done_count", done_cnt - d0, 1);

        // 5) reset in the middle of test 3's first channel
        d0 = done_cnt;
        start_layer(4, 3, 1, 3, 0);
        bus.buf_ack = 1'b0;
        repeat (5) begin
            @(negedge clk);
            bus.buf_ready = 1'b1;
        end
        @(negedge clk);
        bus.buf_ready = 1'b0;
        check("t5_addr_before_rst", 32'(bus.mem_addr), 5);
        rst = 1'b1;
        buf_idle();
        @(negedge clk);
        rst = 1'b0;
        check("t5_ack_after_rst", 32'(bus.ack), 1);
        check("t5_addr_after_rst", 32'(bus.mem_addr), 0);
        check("t5_ch_after_rst", 32'(bus.ch_count), 0);
        check("t5_no_done", done_cnt - d0, 0);
        start_layer(4, 3, 1, 1, 'h40);
        run_ch(16, 16, 0, 0, 0, 'h40, 1, 1, 0, 1);
        check("t5_fresh_done", done_cnt - d0, 1);

        // 6) req with a different img_size during S_RUN is ignored
        d0 = done_cnt;
        start_layer(4, 3, 1, 1, 'h200);
        run_ch(16, 16, 0, 1, 1, 'h200, 1, 1, 0, 1);
        check("t6_done_count", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
